// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and request legality helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we)
      return !(f3 inside {F3_B, F3_H, F3_W});
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the datapath (master) and the data-memory
// responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and replicated data, plus load lane
// extraction with sign/zero extension. Purely combinational.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = '0;
    o_wdata = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      2'b10:   o_be = '1;
      default: o_be = '0;
    endcase
  end

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'd0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'd0, w_half};
      F3_W:    o_rdata = i_rword;
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, request FSM and fixed response latency.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]   r_mem [DEPTH_WORDS];
  state_t        r_state, w_next;
  logic [3:0]    r_cnt, w_cnt_next;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_req_ready, w_accept, w_err, w_align_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword, w_wdata_rep, w_rdata_ext;
  logic [3:0]    w_be;

  always_comb begin
    w_idx   = bus.req_addr[AW+1:2];
    w_rword = r_mem[w_idx];
`ifdef DMEM_MISALIGN_TRAP_EN
    w_align_err = misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
    w_align_err = 1'b0;
`endif
    w_err = (bus.req_addr[31:2] >= 30'(DEPTH_WORDS))
          | f3_illegal(bus.req_we, bus.req_funct3)
          | w_align_err;
  end

  dmem_lane_align u_align (
    .i_funct3  (bus.req_funct3),
    .i_addr_lo (bus.req_addr[1:0]),
    .i_wdata   (bus.req_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_rdata_ext)
  );

  // Acceptance always passes through WAIT; leaving it when cnt reaches 0
  // puts rsp_valid exactly LATENCY edges after acceptance, including LATENCY=1.
  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_req_ready = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = reset;
        w_accept    = bus.req_valid && reset;
        if (w_accept) begin
          w_next     = WAIT;
          w_cnt_next = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_next = RESP;
        else               w_cnt_next = r_cnt - 4'd1;
      end
      RESP:    if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The extended result is captured with the RAM word at acceptance and only
  // becomes observable once RESP is entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_err   <= w_err;
        r_rdata <= (w_err || bus.req_we) ? '0 : w_rdata_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && bus.req_we && !w_err) begin
      for (int unsigned i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule
